// File: rtl/lif_chain.sv
// Cascade of N leaky integrate-and-fire neurons sharing one input current, with
// a run-time threshold, refractory hold-off and a saturating output spike counter.
module lif_chain #(
    parameter int          N           = 4,
    parameter int          W           = 8,
    parameter int          LEAK_SHIFT  = 1,
    parameter logic [W-1:0] SYN_W      = 8'd40,
    parameter int          REFRACT     = 2,
    parameter int          THRESH_INIT = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [W-1:0]         current,
    input  logic                 cfg_we,
    input  logic [W-1:0]         cfg_thresh,
    input  logic [$clog2(N)-1:0] sel,
    input  logic                 cnt_clr,
    output logic [N-1:0]         spike,
    output logic [W-1:0]         state_out,
    output logic [7:0]           spike_cnt
);

    localparam int SELW = $clog2(N);
    localparam int RW   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam logic [RW-1:0] REFR_LOAD = RW'(REFRACT);

    logic [W-1:0]   thresh_reg;
    logic [7:0]     cnt_reg;
    logic [N-1:0]   spike_reg;
    logic [N*W-1:0] state_flat;

    for (genvar gi = 0; gi < N; gi++) begin : g_neuron
        logic [W-1:0]  state_reg;
        logic [RW-1:0] refr_reg;
        logic          spike_bit_reg;
        logic [W-1:0]  in_k;
        logic [W-1:0]  leaked;
        logic [W:0]    sum_wide;
        logic [W-1:0]  sum;

        if (gi == 0) begin : g_head
            assign in_k = current;
        end else begin : g_tail
            // Predecessor's registered spike adds the synaptic weight one edge after it fires
            logic [W:0] in_wide;
            assign in_wide = {1'b0, current}
                           + (spike_reg[gi-1] ? {1'b0, SYN_W} : {(W+1){1'b0}});
            assign in_k = in_wide[W] ? {W{1'b1}} : in_wide[W-1:0];
        end

        assign leaked   = state_reg - (state_reg >> LEAK_SHIFT);
        assign sum_wide = {1'b0, leaked} + {1'b0, in_k};
        assign sum      = sum_wide[W] ? {W{1'b1}} : sum_wide[W-1:0];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_reg     <= '0;
                refr_reg      <= '0;
                spike_bit_reg <= 1'b0;
            end else if (en) begin
                if (refr_reg != '0) begin
                    state_reg     <= '0;
                    refr_reg      <= refr_reg - RW'(1);
                    spike_bit_reg <= 1'b0;
                end else if (sum >= thresh_reg) begin
                    state_reg     <= '0;
                    refr_reg      <= REFR_LOAD;
                    spike_bit_reg <= 1'b1;
                end else begin
                    state_reg     <= sum;
                    spike_bit_reg <= 1'b0;
                end
            end
        end

        assign spike_reg[gi]            = spike_bit_reg;
        assign state_flat[gi*W +: W]    = state_reg;
    end

    // Threshold writes land regardless of en; compares on the same edge see the old value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_reg <= W'(THRESH_INIT);
        end else if (cfg_we) begin
            thresh_reg <= cfg_thresh;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (cnt_clr) begin
            cnt_reg <= '0;
        end else if (spike_reg[N-1] && (cnt_reg != 8'hFF)) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    always_comb begin
        state_out = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                state_out = state_flat[i*W +: W];
            end
        end
    end

    assign spike     = spike_reg;
    assign spike_cnt = cnt_reg;

endmodule

// File: doc/lif_chain.md
# lif_chain

Parametrised cascade of N leaky integrate-and-fire neurons, the next generation of the two-neuron LIF demo top. It adds configurable width, chain depth, leak shift, synaptic weight, a run-time threshold, refractory periods and an output spike counter. Neuron 0 integrates the external current. Each later neuron integrates the same current plus a weighted spike from its predecessor. The block sits directly behind the tile's input switches, and its outputs are muxed onto the 7-segment and bidirectional pins.

## Interface
Parameters:
- N, 4: number of neurons in the chain (≥2)
- W, 8: membrane / current / threshold width, in bits
- LEAK_SHIFT, 1: leak divisor exponent; leak = state >> LEAK_SHIFT (1..W-1)
- SYN_W, 8'd40: weight added to neuron k's input when spike[k-1] is high (W bits)
- REFRACT, 2: refractory cycles after a spike (0 disables refractory)
- THRESH_INIT, 200: threshold value at reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  update enable; when low, all neuron state, refractory counters and spikes hold
- current  in  W  external input current, unsigned
- cfg_we  in  1  threshold write strobe
- cfg_thresh  in  W  new threshold value
- sel  in  clog2(N)  neuron index for state_out
- cnt_clr  in  1  synchronous clear of spike_cnt
- spike  out  N  registered spike flags, one per neuron
- state_out  out  W  membrane of neuron sel (combinational mux of registers)
- spike_cnt  out  8  saturating count of spike[N-1] events

## Operation
- Neuron k input:
  - k=0: I_0 = current.
  - k>0: I_k = sat_W(current + (spike[k-1] ? SYN_W : 0)).
  - spike[k-1] is the registered value, so a spike reaches the next stage one cycle later.
- Per-neuron update, each edge with en=1:
  - leaked = state − (state >> LEAK_SHIFT).
  - sum = sat_W(leaked + I_k), computed in W+1 bits and clamped to 2^W−1.
  - If refr > 0: state ← 0, refr ← refr−1, spike ← 0.
  - Else if sum ≥ thresh: spike ← 1, state ← 0, refr ← REFRACT.
  - Else: state ← sum, spike ← 0.
- A spike is a single-cycle pulse. It cannot repeat on consecutive enabled cycles when REFRACT ≥ 1.
- Threshold:
  - A shared register, reset to THRESH_INIT.
  - cfg_we=1 loads cfg_thresh on that edge. The new value is used from the next edge onward.
  - A write on the same edge as a compare does not affect that compare.
  - The write is accepted regardless of en.
- thresh = 0 means every non-refractory enabled cycle spikes.
- spike_cnt:
  - Increments on each edge where the spike[N-1] register is 1 (counts pulses, independent of en), saturating at 255.
  - cnt_clr takes priority over increment and zeroes the counter.
- sel ≥ N: state_out = 0.

## Timing
- Reset values: every neuron state = 0, every refr = 0, spike = 0, thresh = THRESH_INIT, spike_cnt = 0. state_out therefore reads 0.
- Reset is asynchronous on assertion and takes effect immediately, including mid-refractory or mid-integration. Release is synchronous to the next rising clk.
- Latency:
  - current → neuron 0 state: 1 edge.
  - Neuron k spike → neuron k+1 sees SYN_W: on the following edge.
  - spike[N-1] → spike_cnt: +1 edge.
- en=0 freezes every neuron state, refr and spike. A spike held high under en=0 stays high and is counted once per edge.
- Simultaneous cfg_we and a spike: the compare uses the old threshold.
- Simultaneous cnt_clr and spike[N-1]=1: spike_cnt = 0.

## Test plan
- Reset value check: assert rst mid-run with state 180 → spike=0, state_out=0, spike_cnt=0 immediately, without waiting for an edge. Then thresh reads back as 200 via the behaviour below.
- Integration and fire (W=8, LEAK_SHIFT=1, THRESH 200, REFRACT 2): current=120, en=1, sel=0.
  - Edges 1–3: state_out 120, 180, then spike[0]=1 with state 0.
  - Edges 4–5: spike[0]=0 and state stays 0 (refractory).
  - Edge 6: state 120.
- Leak only: load neuron 0 to 180, set current=0 → state 90, 45, 23, 12, 6, …; no spike.
- Chain propagation: current=120, SYN_W=40.
  - spike[1] input is 160 on the edge after spike[0].
  - spike[1] fires no earlier than one edge after spike[0].
  - spike[N-1] eventually fires and spike_cnt increments one edge later.
- Threshold write: cfg_we with cfg_thresh=100 on the same edge that state goes 0→120.
  - That edge does not spike under the old threshold of 200.
  - The next edge, with sum 180 ≥ 100, spikes.
- Saturation and enable:
  - current=255, thresh=255 → sum clamps to 255 and spikes.
  - With en=0 the state holds for 10 edges.
  - Force 300 spike[N-1] pulses → spike_cnt=255; cnt_clr → 0.
